flick_conditioner: RTL

Conditions the raw, asynchronous `flick` push-button into clean, clock-synchronous control for the bound-flasher stage directly downstream. Raw input is synchronized, debounced, and converted into a stable level (`flick`) plus a single-cycle press pulse and optional auto-repeat pulses. An accepted-press counter is exposed for debug.

---
 rtl/flick_conditioner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/flick_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, single-cycle press
// pulse, auto-repeat while held, and an 8-bit accepted-press counter.
module flick_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 32,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flick_raw,
  input  logic       repeat_en,
  output logic       flick,
  output logic       flick_pulse,
  output logic       flick_repeat,
  output logic [7:0] press_count
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  // Reload value makes every repeat after the first land REPEAT_CYCLES apart.
  localparam logic [15:0] REP_LOAD  = (REPEAT_CYCLES > HOLD_CYCLES) ? 16'd0
                                      : 16'(HOLD_CYCLES - REPEAT_CYCLES);

  logic        s1_r, s2_r;
  logic [1:0]  state_r, state_s;
  logic [15:0] db_cnt_r, db_cnt_s;
  logic [15:0] rep_cnt_r, rep_cnt_s;
  logic        flick_s, pulse_s, repeat_s;
  logic [7:0]  count_s;

  // Debounce/repeat next-state logic
  always_comb begin
    state_s   = state_r;
    db_cnt_s  = db_cnt_r;
    rep_cnt_s = rep_cnt_r;
    flick_s   = flick;
    pulse_s   = 1'b0;
    repeat_s  = 1'b0;
    count_s   = press_count;
    case (state_r)
      IDLE: begin
        flick_s = 1'b0;
        if (s2_r) begin
          state_s  = PRESS_WAIT;
          db_cnt_s = 16'd0;
        end else begin
          state_s  = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_r) begin
          state_s = IDLE;
        end else if (db_cnt_r == DB_LAST) begin
          state_s   = HELD;
          flick_s   = 1'b1;
          pulse_s   = 1'b1;
          count_s   = press_count + 8'd1;
          rep_cnt_s = 16'd0;
        end else begin
          db_cnt_s = db_cnt_r + 16'd1;
        end
      end
      HELD: begin
        if (!s2_r) begin
          state_s  = RELEASE_WAIT;
          db_cnt_s = 16'd0;
        end else if (rep_cnt_r == HOLD_LAST) begin
          repeat_s  = repeat_en;
          rep_cnt_s = REP_LOAD;
        end else begin
          rep_cnt_s = rep_cnt_r + 16'd1;
        end
      end
      RELEASE_WAIT: begin
        if (s2_r) begin
          state_s = HELD;
        end else if (db_cnt_r == DB_LAST) begin
          state_s = IDLE;
          flick_s = 1'b0;
        end else begin
          db_cnt_s = db_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s   = IDLE;
        flick_s   = 1'b0;
        db_cnt_s  = 16'd0;
        rep_cnt_s = 16'd0;
      end
    endcase
  end

  // Synchronizer, FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r         <= 1'b0;
      s2_r         <= 1'b0;
      state_r      <= IDLE;
      db_cnt_r     <= 16'd0;
      rep_cnt_r    <= 16'd0;
      flick        <= 1'b0;
      flick_pulse  <= 1'b0;
      flick_repeat <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      s1_r         <= flick_raw;
      s2_r         <= s1_r;
      state_r      <= state_s;
      db_cnt_r     <= db_cnt_s;
      rep_cnt_r    <= rep_cnt_s;
      flick        <= flick_s;
      flick_pulse  <= pulse_s;
      flick_repeat <= repeat_s;
      press_count  <= count_s;
    end
  end

endmodule
